// File: rtl/sim_mem_pkg.sv
// Shared constants for the simulation memory model: stall source selection,
// LFSR geometry and the supported read-latency ceiling.
package sim_mem_pkg;

   localparam int unsigned STALL_NONE     = 0;
   localparam int unsigned STALL_PERIODIC = 1;
   localparam int unsigned STALL_LFSR     = 2;

   localparam int unsigned LFSR_WIDTH = 16;
   localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

   localparam int unsigned MAX_READ_LATENCY = 8;

   // Galois form: shift right, fold the tap mask in when bit 0 falls out.
   function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/sim_mem_model_stall_gen.sv
// Stall request source for the simulation memory: none, periodic pulse,
// or LFSR-driven pseudo-random pattern.
module sim_stall_gen
   import sim_mem_pkg::*;
#(
   parameter int unsigned    STALL_MODE   = STALL_NONE,
   parameter int unsigned    STALL_PERIOD = 8,
   parameter logic [15:0]    LFSR_SEED    = 16'hACE1
) (
   input  logic clk,
   input  logic rst,
   output logic stall_req
);

   localparam int unsigned CW = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(STALL_PERIOD - 1);
   localparam logic [LFSR_WIDTH-1:0] SEED =
      (LFSR_SEED == '0) ? LFSR_WIDTH'(1) : LFSR_WIDTH'(LFSR_SEED);

   logic [CW-1:0]         cnt;
   logic [LFSR_WIDTH-1:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         lfsr      <= SEED;
         stall_req <= 1'b0;
      end else begin
         cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         lfsr <= lfsr_next(lfsr);
         case (STALL_MODE)
            STALL_NONE:     stall_req <= 1'b0;
            STALL_PERIODIC: stall_req <= (cnt == CNT_LAST);
            STALL_LFSR:     stall_req <= lfsr[0] & lfsr[1];
            default:        stall_req <= 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/sim_mem_model.sv
// Dual-channel simulation memory: read-only instruction port and byte-writable
// data port over one shared array, with pipelined read latency and stall source.
module sim_mem_model
  import sim_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH_LOG2   = 14,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STALL_MODE   = STALL_NONE,
  parameter int unsigned STALL_PERIOD = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter string       INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_en,
  input  logic [31:0]             inst_addr,
  output logic [DATA_WIDTH-1:0]   inst_rdata,
  output logic                    inst_rvalid,
  input  logic                    data_en,
  input  logic [DATA_WIDTH/8-1:0] data_wen,
  input  logic [31:0]             data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    data_rvalid,
  output logic                    stall_req,
  output logic                    align_err,
  output logic                    range_err
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF   = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int unsigned WIN   = DEPTH_LOG2 + OFF;
  localparam int unsigned L     = (READ_LATENCY < 1) ? 1 :
                                  (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                                  READ_LATENCY;
  localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);

  function automatic logic misaligned(input logic [31:0] a);
    return (a & ALIGN_MASK) != '0;
  endfunction

  function automatic logic out_of_window(input logic [31:0] a);
    return (a >> WIN) != '0;
  endfunction

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  logic                  inst_acc, data_acc, data_rd;
  logic [DEPTH_LOG2-1:0] inst_idx, data_idx;

  assign inst_acc = inst_en & ~stall_req;
  assign data_acc = data_en & ~stall_req;
  assign data_rd  = data_acc & (data_wen == '0);
  assign inst_idx = inst_addr[WIN-1:OFF];
  assign data_idx = data_addr[WIN-1:OFF];

  sim_stall_gen #(
    .STALL_MODE   (STALL_MODE),
    .STALL_PERIOD (STALL_PERIOD),
    .LFSR_SEED    (LFSR_SEED)
  ) u_stall (
    .clk       (clk),
    .rst       (rst),
    .stall_req (stall_req)
  );

  // Array is deliberately outside the reset domain; only the write is gated.
  always_ff @(posedge clk) begin
    if (!rst && data_acc) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (data_wen[b]) mem[data_idx][b*8 +: 8] <= data_wdata[b*8 +: 8];
      end
    end
  end

  logic                  inst_v [L];
  logic                  data_v [L];
  logic [DATA_WIDTH-1:0] inst_d [L];
  logic [DATA_WIDTH-1:0] data_d [L];

  // Each stage only loads when its predecessor is valid, so the final stage
  // doubles as the rdata register that holds between valid beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < L; i++) begin
        inst_v[i] <= 1'b0;
        data_v[i] <= 1'b0;
        inst_d[i] <= '0;
        data_d[i] <= '0;
      end
    end else begin
      inst_v[0] <= inst_acc;
      data_v[0] <= data_rd;
      if (inst_acc) inst_d[0] <= mem[inst_idx];
      if (data_rd)  data_d[0] <= mem[data_idx];
      for (int unsigned i = 1; i < L; i++) begin
        inst_v[i] <= inst_v[i-1];
        data_v[i] <= data_v[i-1];
        if (inst_v[i-1]) inst_d[i] <= inst_d[i-1];
        if (data_v[i-1]) data_d[i] <= data_d[i-1];
      end
    end
  end

  assign inst_rvalid = inst_v[L-1];
  assign data_rvalid = data_v[L-1];
  assign inst_rdata  = inst_d[L-1];
  assign data_rdata  = data_d[L-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      align_err <= 1'b0;
      range_err <= 1'b0;
    end else begin
      align_err <= align_err | (inst_acc & misaligned(inst_addr))
                             | (data_acc & misaligned(data_addr));
      range_err <= range_err | (inst_acc & out_of_window(inst_addr))
                             | (data_acc & out_of_window(data_addr));
    end
  end

endmodule

// File: tb/tb_sim_mem_model.sv
// Directed bench for sim_mem_model: scoreboarded reads on a latency-3 instance,
// plus periodic and LFSR stall instances checked against cycle models.
module tb_sim_mem_model;

   localparam int unsigned RL = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] d;
      int unsigned due;
   } exp_t;

   exp_t iq[$];
   exp_t dq[$];

   // main instance
   logic        rst_a = 1'b1;
   logic        a_inst_en = 1'b0, a_data_en = 1'b0;
   logic [31:0] a_inst_addr = '0, a_data_addr = '0, a_data_wdata = '0;
   logic [3:0]  a_data_wen = '0;
   logic [31:0] a_inst_rdata, a_data_rdata;
   logic        a_inst_rvalid, a_data_rvalid, a_stall, a_align, a_range;

   sim_mem_model #(
      .DATA_WIDTH   (32),
      .DEPTH_LOG2   (4),
      .READ_LATENCY (RL),
      .STALL_MODE   (0)
   ) u_dut (
      .clk (clk), .rst (rst_a),
      .inst_en (a_inst_en), .inst_addr (a_inst_addr),
      .inst_rdata (a_inst_rdata), .inst_rvalid (a_inst_rvalid),
      .data_en (a_data_en), .data_wen (a_data_wen), .data_addr (a_data_addr),
      .data_wdata (a_data_wdata), .data_rdata (a_data_rdata), .data_rvalid (a_data_rvalid),
      .stall_req (a_stall), .align_err (a_align), .range_err (a_range)
   );

   // stall instances
   logic        rst_s = 1'b1;
   logic        b_inst_en = 1'b0;
   logic        zero1 = 1'b0;
   logic [3:0]  zero4 = '0;
   logic [31:0] zero32 = '0;
   logic [31:0] b_inst_rdata, b_data_rdata, c_inst_rdata, c_data_rdata;
   logic        b_inst_rvalid, b_data_rvalid, b_stall, b_align, b_range;
   logic        c_inst_rvalid, c_data_rvalid, c_stall, c_align, c_range;

   sim_mem_model #(
      .DATA_WIDTH (32), .DEPTH_LOG2 (4), .READ_LATENCY (1),
      .STALL_MODE (1), .STALL_PERIOD (4)
   ) u_per (
      .clk (clk), .rst (rst_s),
      .inst_en (b_inst_en), .inst_addr (zero32),
      .inst_rdata (b_inst_rdata), .inst_rvalid (b_inst_rvalid),
      .data_en (zero1), .data_wen (zero4), .data_addr (zero32),
      .data_wdata (zero32), .data_rdata (b_data_rdata), .data_rvalid (b_data_rvalid),
      .stall_req (b_stall), .align_err (b_align), .range_err (b_range)
   );

   sim_mem_model #(
      .DATA_WIDTH (32), .DEPTH_LOG2 (4), .READ_LATENCY (1),
      .STALL_MODE (2), .LFSR_SEED (16'hACE1)
   ) u_lfsr (
      .clk (clk), .rst (rst_s),
      .inst_en (zero1), .inst_addr (zero32),
      .inst_rdata (c_inst_rdata), .inst_rvalid (c_inst_rvalid),
      .data_en (zero1), .data_wen (zero4), .data_addr (zero32),
      .data_wdata (zero32), .data_rdata (c_data_rdata), .data_rvalid (c_data_rvalid),
      .stall_req (c_stall), .align_err (c_align), .range_err (c_range)
   );

   // scoreboard consumer: every rvalid beat must match the oldest expectation
   always @(negedge clk) begin : sb
      exp_t e;
      if (a_inst_rvalid) begin
         tests++;
         assert (iq.size() > 0) else begin
            fails++; $error("FAIL inst_unexpected obs=rvalid exp=idle cyc=%0d", cyc);
         end
         if (iq.size() > 0) begin
            e = iq.pop_front();
            tests++;
            assert (a_inst_rdata === e.d) else begin
               fails++; $error("FAIL inst_rdata obs=%h exp=%h", a_inst_rdata, e.d);
            end
            tests++;
            assert (cyc === e.due) else begin
               fails++; $error("FAIL inst_latency obs=%0d exp=%0d", cyc, e.due);
            end
         end
      end
      if (a_data_rvalid) begin
         tests++;
         assert (dq.size() > 0) else begin
            fails++; $error("FAIL data_unexpected obs=rvalid exp=idle cyc=%0d", cyc);
         end
         if (dq.size() > 0) begin
            e = dq.pop_front();
            tests++;
            assert (a_data_rdata === e.d) else begin
               fails++; $error("FAIL data_rdata obs=%h exp=%h", a_data_rdata, e.d);
            end
            tests++;
            assert (cyc === e.due) else begin
               fails++; $error("FAIL data_latency obs=%0d exp=%0d", cyc, e.due);
            end
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++; $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      a_data_en = 1'b1; a_data_wen = w; a_data_addr = a; a_data_wdata = d;
      step();
      a_data_en = 1'b0; a_data_wen = '0;
   endtask

   task automatic rd_d(input logic [31:0] a, input logic [31:0] exp);
      dq.push_back('{exp, cyc + RL});
      a_data_en = 1'b1; a_data_wen = '0; a_data_addr = a;
      step();
      a_data_en = 1'b0;
   endtask

   task automatic rd_i(input logic [31:0] a, input logic [31:0] exp);
      iq.push_back('{exp, cyc + RL});
      a_inst_en = 1'b1; a_inst_addr = a;
      step();
      a_inst_en = 1'b0;
   endtask

   task automatic drain;
      int n = 0;
      while ((iq.size() != 0 || dq.size() != 0) && n < 20) begin
         step();
         n++;
      end
      tests++;
      assert (iq.size() == 0 && dq.size() == 0) else begin
         fails++; $error("FAIL drain_timeout obs=%0d/%0d pending exp=0/0", iq.size(), dq.size());
      end
   endtask

   localparam logic [31:0] W0 = 32'hCAFE0000;
   localparam logic [31:0] W1 = 32'h0BADF00D;
   localparam logic [31:0] W2 = 32'h12345678;

   initial begin
      logic [15:0] ml;
      logic        ms, pb, eb_stall;

      // stall generators
      step(); step();
      check("per_stall_rst", {31'd0, b_stall}, 32'd0);
      check("lfsr_stall_rst", {31'd0, c_stall}, 32'd0);
      rst_s = 1'b0;
      b_inst_en = 1'b1;
      ml = 16'hACE1; ms = 1'b0; pb = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         eb_stall = ((k % 4) == 0);
         check($sformatf("per_stall_k%0d", k), {31'd0, b_stall}, {31'd0, eb_stall});
         check($sformatf("per_rvalid_k%0d", k), {31'd0, b_inst_rvalid}, {31'd0, ~pb});
         pb = eb_stall;
         ms = ml[0] & ml[1];
         ml = ml[0] ? ((ml >> 1) ^ 16'hB400) : (ml >> 1);
         check($sformatf("lfsr_stall_k%0d", k), {31'd0, c_stall}, {31'd0, ms});
      end
      b_inst_en = 1'b0;

      // main instance reset values
      step();
      check("rst_inst_rdata", a_inst_rdata, 32'd0);
      check("rst_data_rdata", a_data_rdata, 32'd0);
      check("rst_inst_rvalid", {31'd0, a_inst_rvalid}, 32'd0);
      check("rst_data_rvalid", {31'd0, a_data_rvalid}, 32'd0);
      check("rst_stall", {31'd0, a_stall}, 32'd0);
      check("rst_align", {31'd0, a_align}, 32'd0);
      check("rst_range", {31'd0, a_range}, 32'd0);
      rst_a = 1'b0;

      // writes, byte strobe, back-to-back reads
      wr(32'h0, 4'hF, W0);
      wr(32'h4, 4'hF, W1);
      wr(32'h8, 4'hF, W2);
      wr(32'h10, 4'hF, 32'h11223344);
      wr(32'h10, 4'b0010, 32'hAABBCCDD);
      rd_d(32'h0, W0);
      rd_d(32'h4, W1);
      rd_d(32'h8, W2);
      rd_d(32'h10, 32'h1122CC44);
      drain();
      step(); step();
      check("data_rdata_hold", a_data_rdata, 32'h1122CC44);
      check("data_rvalid_idle", {31'd0, a_data_rvalid}, 32'd0);

      // collision: same-cycle write + inst read sees old data, next cycle new
      wr(32'h20, 4'hF, 32'd5);
      a_data_en = 1'b1; a_data_wen = 4'hF; a_data_addr = 32'h20; a_data_wdata = 32'd9;
      a_inst_en = 1'b1; a_inst_addr = 32'h20;
      iq.push_back('{32'd5, cyc + RL});
      step();
      a_data_wen = '0;
      iq.push_back('{32'd9, cyc + RL});
      dq.push_back('{32'd9, cyc + RL});
      step();
      a_data_en = 1'b0; a_inst_en = 1'b0;
      drain();
      check("a_stall_idle", {31'd0, a_stall}, 32'd0);

      // reset mid-flight: in-flight read dies, reset-cycle write suppressed
      a_data_en = 1'b1; a_data_wen = '0; a_data_addr = 32'h0;
      step();
      rst_a = 1'b1;
      a_data_wen = 4'hF; a_data_addr = 32'h4; a_data_wdata = 32'hFFFFFFFF;
      step();
      rst_a = 1'b0; a_data_en = 1'b0; a_data_wen = '0;
      for (int n = 0; n < 6; n++) step();
      check("post_rst_data_rdata", a_data_rdata, 32'd0);
      rd_d(32'h4, W1);
      rd_d(32'h0, W0);
      drain();
      check("pre_err_align", {31'd0, a_align}, 32'd0);
      check("pre_err_range", {31'd0, a_range}, 32'd0);

      // misaligned access truncates; out-of-window write wraps
      rd_i(32'h2, W0);
      check("align_set", {31'd0, a_align}, 32'd1);
      check("range_clear", {31'd0, a_range}, 32'd0);
      wr(32'h40, 4'hF, 32'h7);
      check("range_set", {31'd0, a_range}, 32'd1);
      rd_d(32'h0, 32'h7);
      drain();
      check("align_sticky", {31'd0, a_align}, 32'd1);
      check("range_sticky", {31'd0, a_range}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
